sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Sequential consumer placed directly downstream of the three-operand 3-bit adder. It takes the adder's `{carry, result}` output as a 4-bit unsigned sample through a valid/ready handshake and accumulates a burst of `COUNT` samples (or fewer, on flush). It then presents the total, the number of samples it covers and a sticky overflow flag through a second valid/ready handshake. One clock domain.

## Interface
Parameters:
- `COUNT`, default 4, number of samples per burst (≥2)
- `W_ACC`, default 8, accumulator and `out_sum` width (≥4)
- `W_CNT`, default 3, sample counter width; must satisfy 2^W_CNT > COUNT

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream sample valid
- `in_ready`  out  1  block can accept a sample
- `in_result`  in  3  adder result bits
- `in_carry`  in  1  adder carry; sample = `{in_carry, in_result}` (0..15)
- `flush`  in  1  close the current burst early
- `out_valid`  out  1  total available
- `out_ready`  in  1  downstream accepts total
- `out_sum`  out  W_ACC  accumulated total, modulo 2^W_ACC
- `out_count`  out  W_CNT  samples included in `out_sum`
- `out_overflow`  out  1  some addition in this burst carried out of W_ACC
- `busy`  out  1  high in ACCUM or HOLD

## Operation
- FSM states:
  - IDLE: count = 0, acc = 0.
  - ACCUM: 0 < count < COUNT.
  - HOLD: result presented.
- `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD. A sample is accepted when `in_valid & in_ready`.
- On accept:
  - acc ← acc + zero-extended sample, modulo 2^W_ACC.
  - count ← count + 1.
  - ovf ← ovf | carry-out of that addition.
- Transitions:
  - IDLE → ACCUM on accept, when COUNT > 1.
  - ACCUM → HOLD on the accept that makes count = COUNT.
  - ACCUM → HOLD on `flush`. If a sample is accepted in the same cycle, it is included before HOLD.
  - IDLE with `flush`: ignored, even with a simultaneous accept. The sample is accumulated normally and the state goes to ACCUM.
  - HOLD → IDLE on `out_valid & out_ready`. acc, count and ovf clear to 0.
- In HOLD:
  - `out_sum`, `out_count` and `out_overflow` are stable.
  - `flush` and `in_valid` are ignored.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, acc 0, count 0, ovf 0; `in_ready` 1, `out_valid` 0, `out_sum` 0, `out_count` 0, `out_overflow` 0, `busy` 0.
- `rst` mid-burst or in HOLD discards all data. Reset values apply the cycle after the `rst` edge, and `rst` overrides every other input.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid`, `flush` or `out_ready` to any output.
- Latency: `out_valid` rises the cycle after the final accept or the flush edge.
- Zero-backpressure throughput: COUNT accept cycles, then 1 HOLD cycle, then IDLE. A new sample can be accepted the cycle after the output handshake, giving a minimum of COUNT+1 cycles per burst.
- `out_valid` stays high until `out_ready` is sampled high. It never drops without a handshake, except on `rst`.
- The output values reflect all accepted samples, including the terminal one.

## Test plan
- Basic burst: defaults, `out_ready`=1, samples 3, 7, 15, 1 on consecutive cycles. Required: `out_valid` high one cycle after the 4th accept; `out_sum`=26, `out_count`=4, `out_overflow`=0; `in_ready` is 0 that cycle and 1 the next.
- Overflow: `W_ACC`=5, `COUNT`=3, samples 15, 15, 15. Required: `out_sum`=13 (45 mod 32), `out_overflow`=1.
- Backpressure: as the basic burst but `out_ready`=0 for 5 cycles in HOLD, with `in_valid`=1 and `flush` pulsed during that time. Required: outputs hold 26/4/0, `in_ready`=0 and no sample is absorbed; IDLE follows the cycle after `out_ready`=1.
- Flush:
  - Samples 5, 6, then `flush`. Required: `out_sum`=11, `out_count`=2.
  - Sample 9 with `flush` in the same ACCUM cycle after sample 4. Required: `out_sum`=13, `out_count`=2.
  - `flush` alone in IDLE. Required: no state change.
- Reset mid-operation: assert `rst` after 2 samples. Required: all outputs at reset values. A following burst of 1, 1, 1, 1 gives `out_sum`=4 with no stale data.
- Input gaps: defaults, `in_valid` toggled 1-0-1-0 with samples 2, 4, 6, 8 on the high cycles. Required: only valid cycles count; `out_sum`=20, `out_count`=4.

Source files
------------

// File: rtl/sum_accumulator.sv
// Accumulates bursts of 4-bit {carry, result} samples from the 3-operand adder
// and hands the total, the sample count and a sticky overflow flag downstream.
module sum_accumulator #(
    parameter int COUNT = 4,
    parameter int W_ACC = 8,
    parameter int W_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_result,
    input  logic             in_carry,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_ACC-1:0] out_sum,
    output logic [W_CNT-1:0] out_count,
    output logic             out_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [W_CNT-1:0] COUNT_L = W_CNT'(COUNT);

    state_t           state_q, state_d;
    logic [W_ACC-1:0] acc_q, acc_d;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic [W_ACC:0]   sum_ext;

    // Returns {carry_out, acc + sample} so the carry feeds the sticky flag.
    function automatic logic [W_ACC:0] add_sample(input logic [W_ACC-1:0] a,
                                                  input logic [3:0]       s);
        return {1'b0, a} + {{(W_ACC-3){1'b0}}, s};
    endfunction

    assign accept  = in_valid && (state_q != HOLD);
    assign sum_ext = add_sample(acc_q, {in_carry, in_result});

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                // flush is deliberately ignored here: an empty burst is never emitted
                if (accept) begin
                    acc_d   = sum_ext[W_ACC-1:0];
                    cnt_d   = W_CNT'(1);
                    ovf_d   = sum_ext[W_ACC];
                    state_d = (COUNT_L == W_CNT'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_ext[W_ACC-1:0];
                    cnt_d = cnt_q + W_CNT'(1);
                    ovf_d = ovf_q | sum_ext[W_ACC];
                end
                if (flush || (cnt_d == COUNT_L)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode registered state only; nothing combinational from inputs.
    assign in_ready     = (state_q != HOLD);
    assign out_valid    = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign out_sum      = acc_q;
    assign out_count    = cnt_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus a narrow
// W_ACC=5/COUNT=3 instance for the overflow scenario.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_carry, flush, out_ready;
    logic [2:0] in_result;
    logic       in_ready, out_valid, out_overflow, busy;
    logic [7:0] out_sum;
    logic [2:0] out_count;

    logic       in_valid2, in_carry2, flush2, out_ready2;
    logic [2:0] in_result2;
    logic       in_ready2, out_valid2, out_overflow2, busy2;
    logic [4:0] out_sum2;
    logic [2:0] out_count2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sum_accumulator #(.COUNT(4), .W_ACC(8), .W_CNT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_overflow(out_overflow), .busy(busy)
    );

    sum_accumulator #(.COUNT(3), .W_ACC(5), .W_CNT(3)) dut_ovf (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_result(in_result2), .in_carry(in_carry2), .flush(flush2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2),
        .out_count(out_count2), .out_overflow(out_overflow2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] s);
        in_valid = 1'b1;
        {in_carry, in_result} = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [3:0] s);
        in_valid2 = 1'b1;
        {in_carry2, in_result2} = s;
        step();
        in_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({in_ready, out_valid, busy, out_overflow} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 1000", {in_ready, out_valid, busy, out_overflow});
        end
        vectors++;
        if ({out_sum, out_count} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_data got sum=%0d cnt=%0d exp 0/0", out_sum, out_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(4'd3);
        send(4'd7);
        send(4'd15);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_valid got %b exp 0", out_valid);
        end
        send(4'd1);
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL basic_hold_ctrl got %b exp 101", {out_valid, in_ready, busy});
        end
        vectors++;
        if (out_sum !== 8'd26 || out_count !== 3'd4 || out_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result got %0d/%0d/%0d exp 26/4/0", out_sum, out_count, out_overflow);
        end
        step();
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_sum !== 8'd0) begin
            miscompares++;
            $display("FAIL basic_return_idle got ctrl=%b sum=%0d exp 010/0", {out_valid, in_ready, busy}, out_sum);
        end
    endtask

    task automatic test_overflow();
        out_ready2 = 1'b0;
        send2(4'd15);
        send2(4'd15);
        send2(4'd15);
        vectors++;
        if (out_valid2 !== 1'b1 || out_sum2 !== 5'd13 || out_count2 !== 3'd3 || out_overflow2 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_result got v=%b %0d/%0d/%0d exp 1 13/3/1", out_valid2, out_sum2, out_count2, out_overflow2);
        end
        out_ready2 = 1'b1;
        step();
        send2(4'd1);
        send2(4'd1);
        send2(4'd1);
        vectors++;
        if (out_valid2 !== 1'b1 || out_sum2 !== 5'd3 || out_overflow2 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_cleared got v=%b sum=%0d ovf=%0d exp 1 3 0", out_valid2, out_sum2, out_overflow2);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(4'd3);
        send(4'd7);
        send(4'd15);
        send(4'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            {in_carry, in_result} = 4'd5;
            flush = (i == 2);
            step();
            vectors++;
            if ({out_valid, in_ready} !== 2'b10 || out_sum !== 8'd26 || out_count !== 3'd4 || out_overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d got ctrl=%b %0d/%0d/%0d exp 10 26/4/0", i, {out_valid, in_ready}, out_sum, out_count, out_overflow);
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_sum !== 8'd0) begin
            miscompares++;
            $display("FAIL bp_release got ctrl=%b sum=%0d exp 010/0", {out_valid, in_ready, busy}, out_sum);
        end
    endtask

    task automatic test_flush();
        send(4'd5);
        send(4'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 8'd11 || out_count !== 3'd2) begin
            miscompares++;
            $display("FAIL flush_plain got v=%b %0d/%0d exp 1 11/2", out_valid, out_sum, out_count);
        end
        step();
        send(4'd4);
        flush = 1'b1;
        send(4'd9);
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 8'd13 || out_count !== 3'd2) begin
            miscompares++;
            $display("FAIL flush_with_sample got v=%b %0d/%0d exp 1 13/2", out_valid, out_sum, out_count);
        end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010 || out_sum !== 8'd0 || out_count !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_idle got ctrl=%b sum=%0d cnt=%0d exp 010/0/0", {out_valid, in_ready, busy}, out_sum, out_count);
        end
        flush = 1'b1;
        send(4'd2);
        vectors++;
        if ({out_valid, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush_idle_accept got v/busy=%b exp 01", {out_valid, busy});
        end
        step();
        flush = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 8'd2 || out_count !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_single got v=%b %0d/%0d exp 1 2/1", out_valid, out_sum, out_count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        send(4'd1);
        send(4'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, busy, out_overflow} !== 4'b1000 || out_sum !== 8'd0 || out_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid got ctrl=%b sum=%0d cnt=%0d exp 1000/0/0", {in_ready, out_valid, busy, out_overflow}, out_sum, out_count);
        end
        for (int i = 0; i < 4; i++) send(4'd1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 8'd4 || out_count !== 3'd4) begin
            miscompares++;
            $display("FAIL reset_fresh_burst got v=%b %0d/%0d exp 1 4/4", out_valid, out_sum, out_count);
        end
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_sum !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_in_hold got ctrl=%b sum=%0d exp 100/0", {in_ready, out_valid, busy}, out_sum);
        end
    endtask

    task automatic test_gaps();
        send(4'd2);
        step();
        send(4'd4);
        step();
        send(4'd6);
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_early_valid got %b exp 0", out_valid);
        end
        send(4'd8);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 8'd20 || out_count !== 3'd4) begin
            miscompares++;
            $display("FAIL gaps_result got v=%b %0d/%0d exp 1 20/4", out_valid, out_sum, out_count);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_carry = 1'b0; in_result = 3'd0; flush = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_carry2 = 1'b0; in_result2 = 3'd0; flush2 = 1'b0; out_ready2 = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
